vend_arb_ctrl: RTL

VEND_ARB_CTRL -- requirements
Module: vend_arb_ctrl

---
 rtl/vend_arb_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vend_arb_ctrl.sv
// rtl/vend_arb_ctrl.sv - coin vending controller with round-robin product arbitration
//
// Purpose: collects 5/10-cent coins into a 4-bit credit (units of 5 cents),
// grants one of four product requests round-robin once credit covers PRICE,
// holds dispense for DISP_CYCLES clocks, then pays back any remaining credit
// one unit per clock on change_pulse. All outputs are registered.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   coin_5       in   one-cycle pulse, +1 unit
//   coin_10      in   one-cycle pulse, +2 units
//   req[3:0]     in   level product requests, bit i = product i
//   cancel       in   level, abort session and return credit
//   sel[1:0]     out  last granted product index
//   dispense     out  high while the product is released
//   change_pulse out  one pulse per returned unit
//   coin_reject  out  one-cycle pulse, coin(s) refused
//   busy         out  high in DISPENSE or CHANGE
//   credit[3:0]  out  current credit in units
module vend_arb_ctrl #(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic [3:0] req,
  input  logic       cancel,
  output logic [1:0] sel,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy,
  output logic [3:0] credit
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_e;

  localparam logic [3:0] PRICE_C   = 4'(PRICE);
  localparam logic [3:0] DISP_LAST = 4'(DISP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dispense_q, dispense_d;
  logic       change_q, change_d;
  logic       reject_q, reject_d;
  logic       busy_q, busy_d;

  logic [1:0] coin_sum;
  logic [4:0] credit_sum;
  logic       open_st;
  logic       cancel_eff;
  logic       grant;
  logic       coin_ok;
  logic       req_hit;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  // Round-robin search starting at ptr_q; 2-bit arithmetic wraps mod 4.
  always_comb begin
    req_hit   = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!req_hit && req[cand]) begin
        req_hit   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign coin_sum   = {1'b0, coin_5} + {coin_10, 1'b0};
  assign credit_sum = {1'b0, credit_q} + {3'b000, coin_sum};
  assign open_st    = (state_q == S_IDLE) || (state_q == S_COLLECT);
  // Cancel only matters when there is a session holding credit.
  assign cancel_eff = cancel && ((state_q == S_COLLECT) ||
                                 ((state_q == S_IDLE) && (credit_q != 4'd0)));
  // Eligibility uses the pre-coin credit of this cycle.
  assign grant      = open_st && !cancel_eff && req_hit && (credit_q >= PRICE_C);
  // Overflow check is on the pre-grant credit so a coin can never wrap.
  assign coin_ok    = open_st && !cancel_eff && (coin_sum != 2'd0) && (credit_sum <= 5'd15);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    reject_d = (coin_sum != 2'd0) && !coin_ok;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel_eff) begin
          state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
        end else if (grant) begin
          state_d  = S_DISPENSE;
          sel_d    = grant_idx;
          ptr_d    = grant_idx + 2'd1;
          cnt_d    = DISP_LAST;
          credit_d = credit_q - PRICE_C + (coin_ok ? {2'b00, coin_sum} : 4'd0);
        end else if (coin_ok) begin
          state_d  = S_COLLECT;
          credit_d = credit_sum[3:0];
        end
      end
      S_DISPENSE: begin
        if (cnt_q == 4'd0) begin
          state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHANGE: begin
        if (credit_q != 4'd0) begin
          credit_d = credit_q - 4'd1;
        end
        if (credit_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs track the state being entered so they register with it.
    dispense_d = (state_d == S_DISPENSE);
    change_d   = (state_d == S_CHANGE);
    busy_d     = dispense_d || change_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      credit_q   <= 4'd0;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      cnt_q      <= 4'd0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign sel          = sel_q;
  assign dispense     = dispense_q;
  assign change_pulse = change_q;
  assign coin_reject  = reject_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule
